vga_out_stage: RTL and testbench
================================

Name: vga_out_stage

Overview:
Parametrised VGA output stage between the pixel source (frame buffer / detector pipeline) and the resistor DAC pins. It carries generic per-channel colour depth and a configurable pipeline latency. Syncs pass through independently of blanking, with selectable output polarity. Frame-synchronous display modes: passthrough, colour bars, solid colour and grayscale. It also keeps internal pixel/line/frame counters.

Parameters:
IN_BPC, 4, input bits per colour channel (i_pixel width = 3*IN_BPC, packed R|G|B, R in MSBs)
OUT_BPC, 4, output bits per colour channel
LAT, 2, input-to-output latency in clocks (legal range 2..8)
HS_NEG, 1, 1 = o_HS inverted relative to i_hsync
VS_NEG, 1, 1 = o_VS inverted relative to i_vsync
BAR_W, 80, colour-bar width in active pixels
XW, 11, width of x/y counters

Ports:
i_p_clk  in  1  pixel clock
i_rstn  in  1  asynchronous active-low reset
i_pixel  in  3*IN_BPC  pixel, R|G|B
i_hsync  in  1  hsync, active-high
i_vsync  in  1  vsync, active-high
i_active_area  in  1  pixel valid/visible
i_mode  in  2  0 pass, 1 bars, 2 solid, 3 gray
i_solid  in  3*IN_BPC  colour for mode 2
o_R / o_G / o_B  out  OUT_BPC each  DAC channels
o_HS  out  1  hsync after polarity
o_VS  out  1  vsync after polarity
o_frame_cnt  out  16  frames since reset

Behaviour:
- Clock and reset: one clock, i_p_clk. Reset is asynchronous and active-low on i_rstn; all flops clear immediately when it asserts.
- Reset values: o_R/o_G/o_B = 0; o_HS = HS_NEG; o_VS = VS_NEG (inactive level); o_frame_cnt = 0; x = y = 0; active mode register = 0; all delay-line stages cleared to 0 and inactive.
- Latency: every output reflects inputs sampled exactly LAT clocks earlier. Colour, active and syncs share one delay, so there is no skew between them.
  - Stage 1: register inputs and counters.
  - Stage 2: mode colour generation, width conversion and blanking.
  - Stages 3..LAT: plain delay.
- Sync path: o_HS = delayed i_hsync XOR HS_NEG; o_VS = delayed i_vsync XOR VS_NEG. Syncs are never blanked by i_active_area.
- Blanking: when delayed active = 0, colour outputs = 0 regardless of mode.
- x counter:
  - Increments on each active cycle.
  - Clears on the cycle after an active falling edge.
  - Holds during blanking.
  - Wraps at 2^XW.
- y counter:
  - Increments on each active falling edge (end of line).
  - Clears on the i_vsync rising edge.
- Frame counter: o_frame_cnt increments on each i_vsync rising edge (0→1 between consecutive samples) and wraps 0xFFFF→0.
- Mode latch: i_mode is captured into the active-mode register only on the i_vsync rising edge. Mid-frame i_mode changes have no effect until the next frame.
- Mode 1, colour bars:
  - Bar index b = x / BAR_W, saturated at 7.
  - Colour order b = 0..7: white, yellow, cyan, green, magenta, red, blue, black.
  - Channel = all-ones or 0: R on for b in {0,1,4,5}; G on for b in {0,1,2,3}; B on for b in {0,2,4,6}.
- Mode 2, solid: output i_solid, sampled in stage 1.
- Mode 3, gray:
  - g = (R + 2G + B) >> 2, computed at IN_BPC+2 bits with no overflow.
  - Result truncated to IN_BPC and driven on all three channels.
- Width conversion, per channel, applied after mode selection:
  - OUT_BPC ≤ IN_BPC: take the top OUT_BPC bits.
  - OUT_BPC > IN_BPC: MSB-replicate to fill the low bits (e.g. 4→8: 0xA → 0xAA).
- Simultaneous vsync rise and active fall in the same cycle: y clears (vsync wins), and the frame counter and mode still update.
- Reset mid-frame: outputs return to reset values asynchronously. After release the block resumes on the next sampled inputs; mode stays 0 until the first vsync rising edge.

Optional Feature:
BBOX_OVERLAY_EN
- Defined:
  - Adds ports i_bb_x0, i_bb_x1, i_bb_y0, i_bb_y1 (XW each), i_bb_valid (1) and i_bb_color (3*IN_BPC).
  - Box registers are captured on the i_vsync rising edge when i_bb_valid = 1; otherwise the previous box is held.
  - When the box is enabled and the pixel lies on the outline, stage 2 replaces the mode colour with i_bb_color (before width conversion). Outline: (x==x0 or x==x1) with y0≤y≤y1, or (y==y0 or y==y1) with x0≤x≤x1.
  - Blanking still wins over the overlay.
- Undefined: no extra ports and no overlay logic; behaviour exactly as above.

Test Plan:
- Reset: hold i_rstn=0 with toggling inputs → RGB=0, o_HS=1, o_VS=1 (HS_NEG=VS_NEG=1), o_frame_cnt=0; asserting i_rstn mid-line clears outputs in the same cycle, without waiting for a clock edge.
- Latency and blanking (LAT=3, mode 0): single active pixel 0xF0A between blank pixels → exactly 3 clocks later RGB=F,0,A for one cycle, 0 otherwise; a 1-cycle hsync pulse appears on o_HS inverted at the same offset.
- Frame-synchronous mode: set i_mode=1 mid-frame → output unchanged until the next vsync rise; then with 640-pixel lines and BAR_W=80, pixels 0,80,...,560 give white, yellow, cyan, green, magenta, red, blue, black; x ≥ 640 stays black.
- Gray and width (IN_BPC=4, OUT_BPC=8, mode 3): pixel R=8,G=4,B=0 → g=4 → RGB=0x44,0x44,0x44; mode 2 with i_solid=0xA5F → 0xAA,0x55,0xFF.
- Counters: 3 vsync pulses → o_frame_cnt=3; preload near 0xFFFF and pulse vsync → wraps to 0; vsync rise coinciding with active fall → y=0.
- BBOX_OVERLAY_EN: box (10,20)-(5,8), i_bb_color=0xF00 → red only on the outline pixels within frame, interior pixels pass through; a box written without a vsync rise does not take effect.

Source files
------------

// File: rtl/vga_out_stage.sv
// VGA output stage: frame-latched display mode, width conversion, blanking and polarity-selectable
// syncs behind a LAT-deep delay line. Optional outline overlay enabled by BBOX_OVERLAY_EN.
module vga_out_stage #(
  parameter int IN_BPC  = 4,
  parameter int OUT_BPC = 4,
  parameter int LAT     = 2,
  parameter bit HS_NEG  = 1'b1,
  parameter bit VS_NEG  = 1'b1,
  parameter int BAR_W   = 80,
  parameter int XW      = 11
) (
  input  logic                  i_p_clk,
  input  logic                  i_rstn,
  input  logic [3*IN_BPC-1:0]   i_pixel,
  input  logic                  i_hsync,
  input  logic                  i_vsync,
  input  logic                  i_active_area,
  input  logic [1:0]            i_mode,
  input  logic [3*IN_BPC-1:0]   i_solid,
`ifdef BBOX_OVERLAY_EN
  input  logic [XW-1:0]         i_bb_x0,
  input  logic [XW-1:0]         i_bb_x1,
  input  logic [XW-1:0]         i_bb_y0,
  input  logic [XW-1:0]         i_bb_y1,
  input  logic                  i_bb_valid,
  input  logic [3*IN_BPC-1:0]   i_bb_color,
`endif
  output logic [OUT_BPC-1:0]    o_R,
  output logic [OUT_BPC-1:0]    o_G,
  output logic [OUT_BPC-1:0]    o_B,
  output logic                  o_HS,
  output logic                  o_VS,
  output logic [15:0]           o_frame_cnt
);
  localparam int PW = 3*IN_BPC;
  localparam int CW = 3*OUT_BPC;
  localparam int GW = IN_BPC+2;

  // MSB-replicating resize; degenerates to truncation when OUT_BPC <= IN_BPC
  function automatic logic [OUT_BPC-1:0] widen(input logic [IN_BPC-1:0] c);
    logic [OUT_BPC-1:0] r;
    r = '0;
    for (int i = 0; i < OUT_BPC; i++) r[OUT_BPC-1-i] = c[IN_BPC-1-(i % IN_BPC)];
    return r;
  endfunction

  logic [PW-1:0]  pix_s1_q, pix_s1_d, solid_s1_q, solid_s1_d;
  logic           act_s1_q, act_s1_d, hs_s1_q, hs_s1_d, vs_s1_q, vs_s1_d;
  logic [XW-1:0]  px_s1_q, px_s1_d, x_q, x_d, y_q, y_d;
  logic [15:0]    frame_q, frame_d;
  logic [1:0]     mode_q, mode_d;
  logic           vs_rise, act_fall;

  logic [LAT:2][CW-1:0] rgb_pipe_q, rgb_pipe_d;
  logic [LAT:2]         hs_pipe_q, hs_pipe_d, vs_pipe_q, vs_pipe_d;

  logic [IN_BPC-1:0] r_in, g_in, b_in;
  logic [XW-1:0]     bar_full;
  logic [2:0]        bar;
  logic [GW-1:0]     gsum;
  logic [PW-1:0]     col;

`ifdef BBOX_OVERLAY_EN
  logic [XW-1:0] py_s1_q, py_s1_d;
  logic [XW-1:0] bx0_q, bx0_d, bx1_q, bx1_d, by0_q, by0_d, by1_q, by1_d;
  logic [PW-1:0] bcol_q, bcol_d;
  logic          box_en_q, box_en_d;
  logic          on_box;
`endif

  // Stage 1: sample inputs, tag the pixel with its position, advance counters
  always_comb begin
    vs_rise    = i_vsync & ~vs_s1_q;
    act_fall   = act_s1_q & ~i_active_area;
    pix_s1_d   = i_pixel;
    solid_s1_d = i_solid;
    act_s1_d   = i_active_area;
    hs_s1_d    = i_hsync;
    vs_s1_d    = i_vsync;
    px_s1_d    = x_q;
    x_d        = x_q;
    if (i_active_area) x_d = x_q + XW'(1);
    else if (act_fall) x_d = '0;
    y_d        = y_q;
    if (vs_rise)       y_d = '0;
    else if (act_fall) y_d = y_q + XW'(1);
    frame_d    = frame_q + 16'(vs_rise);
    mode_d     = vs_rise ? i_mode : mode_q;
`ifdef BBOX_OVERLAY_EN
    py_s1_d  = y_q;
    box_en_d = box_en_q;
    bx0_d = bx0_q; bx1_d = bx1_q; by0_d = by0_q; by1_d = by1_q; bcol_d = bcol_q;
    if (vs_rise && i_bb_valid) begin
      box_en_d = 1'b1;
      bx0_d = i_bb_x0; bx1_d = i_bb_x1; by0_d = i_bb_y0; by1_d = i_bb_y1; bcol_d = i_bb_color;
    end
`endif
  end

  // Stage 2: mode colour, overlay, blanking, resize; then plain delay to stage LAT
  always_comb begin
    r_in     = pix_s1_q[PW-1 -: IN_BPC];
    g_in     = pix_s1_q[2*IN_BPC-1 -: IN_BPC];
    b_in     = pix_s1_q[IN_BPC-1:0];
    bar_full = px_s1_q / XW'(BAR_W);
    bar      = (bar_full > XW'(7)) ? 3'd7 : bar_full[2:0];
    gsum     = GW'(r_in) + (GW'(g_in) << 1) + GW'(b_in);
    case (mode_q)
      2'd0:    col = pix_s1_q;
      2'd1:    col = {{IN_BPC{~bar[1]}}, {IN_BPC{~bar[2]}}, {IN_BPC{~bar[0]}}};
      2'd2:    col = solid_s1_q;
      default: col = {3{gsum[GW-1:2]}};
    endcase
`ifdef BBOX_OVERLAY_EN
    on_box = box_en_q &&
             ((((px_s1_q == bx0_q) || (px_s1_q == bx1_q)) && (py_s1_q >= by0_q) && (py_s1_q <= by1_q)) ||
              (((py_s1_q == by0_q) || (py_s1_q == by1_q)) && (px_s1_q >= bx0_q) && (px_s1_q <= bx1_q)));
    if (on_box) col = bcol_q;
`endif
    if (!act_s1_q) col = '0;
    rgb_pipe_d[2] = {widen(col[PW-1 -: IN_BPC]), widen(col[2*IN_BPC-1 -: IN_BPC]), widen(col[IN_BPC-1:0])};
    hs_pipe_d[2]  = hs_s1_q;
    vs_pipe_d[2]  = vs_s1_q;
    for (int i = 3; i <= LAT; i++) begin
      rgb_pipe_d[i] = rgb_pipe_q[i-1];
      hs_pipe_d[i]  = hs_pipe_q[i-1];
      vs_pipe_d[i]  = vs_pipe_q[i-1];
    end
  end

  always_ff @(posedge i_p_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pix_s1_q   <= '0;
      solid_s1_q <= '0;
      act_s1_q   <= 1'b0;
      hs_s1_q    <= 1'b0;
      vs_s1_q    <= 1'b0;
      px_s1_q    <= '0;
      x_q        <= '0;
      y_q        <= '0;
      frame_q    <= '0;
      mode_q     <= '0;
      rgb_pipe_q <= '0;
      hs_pipe_q  <= '0;
      vs_pipe_q  <= '0;
`ifdef BBOX_OVERLAY_EN
      py_s1_q  <= '0;
      box_en_q <= 1'b0;
      bx0_q <= '0; bx1_q <= '0; by0_q <= '0; by1_q <= '0; bcol_q <= '0;
`endif
    end else begin
      pix_s1_q   <= pix_s1_d;
      solid_s1_q <= solid_s1_d;
      act_s1_q   <= act_s1_d;
      hs_s1_q    <= hs_s1_d;
      vs_s1_q    <= vs_s1_d;
      px_s1_q    <= px_s1_d;
      x_q        <= x_d;
      y_q        <= y_d;
      frame_q    <= frame_d;
      mode_q     <= mode_d;
      rgb_pipe_q <= rgb_pipe_d;
      hs_pipe_q  <= hs_pipe_d;
      vs_pipe_q  <= vs_pipe_d;
`ifdef BBOX_OVERLAY_EN
      py_s1_q  <= py_s1_d;
      box_en_q <= box_en_d;
      bx0_q <= bx0_d; bx1_q <= bx1_d; by0_q <= by0_d; by1_q <= by1_d; bcol_q <= bcol_d;
`endif
    end
  end

  assign o_R         = rgb_pipe_q[LAT][CW-1 -: OUT_BPC];
  assign o_G         = rgb_pipe_q[LAT][2*OUT_BPC-1 -: OUT_BPC];
  assign o_B         = rgb_pipe_q[LAT][OUT_BPC-1:0];
  assign o_HS        = hs_pipe_q[LAT] ^ HS_NEG;
  assign o_VS        = vs_pipe_q[LAT] ^ VS_NEG;
  assign o_frame_cnt = frame_q;
endmodule

// File: tb/tb_vga_out_stage.sv
// Bench for vga_out_stage (IN_BPC=4, OUT_BPC=8, LAT=3): random stimulus against a queue-based
// behavioural model of the visible output, plus fixed-value checks for the headline cases.
module tb_vga_out_stage;
  localparam int IN_BPC = 4, OUT_BPC = 8, LAT = 3, BAR_W = 80, XW = 11;

  typedef struct packed { logic [7:0] r, g, b; logic hs, vs; } exp_t;

  logic        clk = 1'b0, rstn = 1'b1;
  logic [11:0] i_pixel = '0, i_solid = '0;
  logic        i_hsync = 1'b0, i_vsync = 1'b0, i_active_area = 1'b0;
  logic [1:0]  i_mode = '0;
  logic [7:0]  o_R, o_G, o_B;
  logic        o_HS, o_VS;
  logic [15:0] o_frame_cnt;
`ifdef BBOX_OVERLAY_EN
  logic [XW-1:0] bb_x0 = '0, bb_x1 = '0, bb_y0 = '0, bb_y1 = '0;
  logic          bb_valid = 1'b0;
  logic [11:0]   bb_color = '0;
`endif

  always #5 clk = ~clk;

  vga_out_stage #(.IN_BPC(IN_BPC), .OUT_BPC(OUT_BPC), .LAT(LAT), .HS_NEG(1'b1), .VS_NEG(1'b1),
                  .BAR_W(BAR_W), .XW(XW)) dut (
    .i_p_clk(clk), .i_rstn(rstn), .i_pixel(i_pixel), .i_hsync(i_hsync), .i_vsync(i_vsync),
    .i_active_area(i_active_area), .i_mode(i_mode), .i_solid(i_solid),
`ifdef BBOX_OVERLAY_EN
    .i_bb_x0(bb_x0), .i_bb_x1(bb_x1), .i_bb_y0(bb_y0), .i_bb_y1(bb_y1),
    .i_bb_valid(bb_valid), .i_bb_color(bb_color),
`endif
    .o_R(o_R), .o_G(o_G), .o_B(o_B), .o_HS(o_HS), .o_VS(o_VS), .o_frame_cnt(o_frame_cnt)
  );

  wire [25:0] obs = {o_R, o_G, o_B, o_HS, o_VS};

  int n_tests = 0, n_fail = 0;
  exp_t q[$];
  exp_t ec;
  bit got;
  logic [15:0] fc;

  int m_x, m_y, m_frame;
  logic [1:0] m_mode;
  bit m_pvs, m_pact;
  logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
`ifdef BBOX_OVERLAY_EN
  bit m_box;
  int m_bx0, m_bx1, m_by0, m_by1;
  logic [11:0] m_bcol;
`endif

  function automatic logic [7:0] w8(input logic [3:0] c);
    return {4'h0, c} * 8'd17;
  endfunction

  // Expected screen output for one sampled input cycle, from the frame/line/pixel rules
  task automatic model_push(input logic [11:0] pix, input bit act, input bit hs, input bit vs,
                            input logic [1:0] md, input logic [11:0] sol);
    bit vr, fl;
    logic [11:0] c;
    exp_t e;
    int bi, gg;
    vr = vs && !m_pvs;
    fl = m_pact && !act;
    if (vr) m_mode = md;
`ifdef BBOX_OVERLAY_EN
    if (vr && bb_valid) begin
      m_box = 1; m_bx0 = int'(bb_x0); m_bx1 = int'(bb_x1); m_by0 = int'(bb_y0); m_by1 = int'(bb_y1);
      m_bcol = bb_color;
    end
`endif
    c = 12'h000;
    if (act) begin
      case (m_mode)
        2'd0: c = pix;
        2'd1: begin bi = m_x / BAR_W; if (bi > 7) bi = 7; c = bars[bi]; end
        2'd2: c = sol;
        default: begin gg = (int'(pix[11:8]) + 2*int'(pix[7:4]) + int'(pix[3:0])) / 4; c = {3{gg[3:0]}}; end
      endcase
`ifdef BBOX_OVERLAY_EN
      if (m_box && ((((m_x == m_bx0) || (m_x == m_bx1)) && m_y >= m_by0 && m_y <= m_by1) ||
                    (((m_y == m_by0) || (m_y == m_by1)) && m_x >= m_bx0 && m_x <= m_bx1))) c = m_bcol;
`endif
    end
    e.r = w8(c[11:8]); e.g = w8(c[7:4]); e.b = w8(c[3:0]);
    e.hs = !hs; e.vs = !vs;
    q.push_back(e);
    if (act) m_x = (m_x + 1) % 2048;
    else if (fl) m_x = 0;
    if (vr) m_y = 0;
    else if (fl) m_y = m_y + 1;
    if (vr) m_frame = (m_frame + 1) % 65536;
    m_pvs = vs; m_pact = act;
  endtask

  // Advance one clock, fetch what the outputs should show now, then apply the next inputs
  task automatic step(input logic [11:0] pix, input bit act, input bit hs, input bit vs,
                      input logic [1:0] md, input logic [11:0] sol);
    @(posedge clk); #1;
    got = 0;
    if (q.size() == LAT) begin ec = q.pop_front(); got = 1; end
    fc = m_frame[15:0];
    i_pixel = pix; i_active_area = act; i_hsync = hs; i_vsync = vs; i_mode = md; i_solid = sol;
    model_push(pix, act, hs, vs, md, sol);
  endtask

  task automatic do_reset();
    exp_t z;
    rstn = 1'b0;
    i_pixel = '0; i_active_area = 0; i_hsync = 0; i_vsync = 0; i_mode = '0; i_solid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    m_x = 0; m_y = 0; m_frame = 0; m_mode = '0; m_pvs = 0; m_pact = 0;
`ifdef BBOX_OVERLAY_EN
    m_box = 0;
`endif
    q.delete();
    z = '{r: 8'h00, g: 8'h00, b: 8'h00, hs: 1'b1, vs: 1'b1};
    for (int i = 0; i < LAT-1; i++) q.push_back(z);
    model_push(12'h000, 0, 0, 0, 2'd0, 12'h000);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    for (int i = 0; i < 6; i++) begin
      i_pixel = 12'($urandom); i_active_area = 1; i_hsync = i[0]; i_vsync = i[1];
      i_mode = 2'($urandom); i_solid = 12'($urandom);
      @(posedge clk); #1;
      n_tests++;
      if (obs !== 26'h3 || o_frame_cnt !== 16'd0) begin
        n_fail++; $display("FAIL reset_hold got=%h frame=%0d want=0000003 frame=0", obs, o_frame_cnt);
      end
    end
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(12'($urandom) | 12'h111, 1, 0, 0, 2'd0, 12'h000);
      if (got) begin n_tests++; if (obs !== ec) begin n_fail++; $display("FAIL reset_run got=%h want=%h", obs, ec); end end
    end
    @(posedge clk); #3;
    rstn = 1'b0;
    #1;
    n_tests++;
    if (obs !== 26'h3 || o_frame_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_async got=%h frame=%0d want=0000003 frame=0", obs, o_frame_cnt);
    end
  endtask

  task automatic test_latency();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(i == 2 ? 12'hF0A : 12'($urandom), i == 2, i == 2, 0, 2'd0, 12'h000);
      if (got) begin n_tests++; if (obs !== ec) begin n_fail++; $display("FAIL latency_model got=%h want=%h", obs, ec); end end
      n_tests++;
      if (obs !== ((i == 2 + LAT) ? {8'hFF, 8'h00, 8'hAA, 1'b0, 1'b1} : 26'h3)) begin
        n_fail++; $display("FAIL latency_fixed cycle=%0d got=%h", i, obs);
      end
    end
  endtask

  task automatic test_mode_latch();
    do_reset();
    for (int l = 0; l < 2; l++)
      for (int c = 0; c < 648; c++) begin
        step(12'($urandom), c < 640, c >= 642 && c < 646, 0, (l == 1 && c >= 100) ? 2'd1 : 2'd0, 12'h000);
        if (got) begin n_tests++; if (obs !== ec) begin n_fail++; $display("FAIL mode_hold got=%h want=%h", obs, ec); end end
      end
    for (int c = 0; c < 6; c++) begin
      step(12'h000, 0, 0, c >= 1 && c < 3, 2'd1, 12'h000);
      if (got) begin n_tests++; if (obs !== ec) begin n_fail++; $display("FAIL mode_vsync got=%h want=%h", obs, ec); end end
    end
    for (int c = 0; c < 712; c++) begin
      step(12'($urandom), c < 704, c >= 706, 0, 2'd1, 12'h000);
      if (got) begin n_tests++; if (obs !== ec) begin n_fail++; $display("FAIL mode_bars got=%h want=%h", obs, ec); end end
    end
  endtask

  task automatic test_gray_solid();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      step(12'h000, 0, 0, c == 1, 2'd3, 12'h000);
      if (got) begin n_tests++; if (obs !== ec) begin n_fail++; $display("FAIL gray_vsync got=%h want=%h", obs, ec); end end
    end
    for (int c = 0; c < 40; c++) begin
      step(c == 0 ? 12'h840 : 12'($urandom), c < 32, 0, 0, 2'd3, 12'h000);
      if (got) begin n_tests++; if (obs !== ec) begin n_fail++; $display("FAIL gray_model got=%h want=%h", obs, ec); end end
      if (c == LAT) begin
        n_tests++;
        if (obs !== {24'h444444, 2'b11}) begin n_fail++; $display("FAIL gray_840 got=%h want=%h", obs, {24'h444444, 2'b11}); end
      end
    end
    for (int c = 0; c < 4; c++) begin
      step(12'h000, 0, 0, c == 1, 2'd2, 12'h000);
      if (got) begin n_tests++; if (obs !== ec) begin n_fail++; $display("FAIL solid_vsync got=%h want=%h", obs, ec); end end
    end
    for (int c = 0; c < 20; c++) begin
      step(12'($urandom), c < 16, 0, 0, 2'd2, c < 8 ? 12'hA5F : 12'($urandom));
      if (got) begin n_tests++; if (obs !== ec) begin n_fail++; $display("FAIL solid_model got=%h want=%h", obs, ec); end end
      if (c == LAT) begin
        n_tests++;
        if (obs !== {24'hAA55FF, 2'b11}) begin n_fail++; $display("FAIL solid_a5f got=%h want=%h", obs, {24'hAA55FF, 2'b11}); end
      end
    end
  endtask

  task automatic test_counters();
    do_reset();
    for (int c = 0; c < 12; c++) begin
      step(12'h000, 0, 0, (c % 4) == 1, 2'd0, 12'h000);
      n_tests++;
      if (o_frame_cnt !== fc) begin n_fail++; $display("FAIL frame_model got=%0d want=%0d", o_frame_cnt, fc); end
    end
    n_tests++;
    if (o_frame_cnt !== 16'd3) begin n_fail++; $display("FAIL frame_three got=%0d want=3", o_frame_cnt); end
    // vsync rises on the very cycle the line ends; next line must restart bars at x=0
    for (int c = 0; c < 304; c++) begin
      if (c < 100)      step(12'($urandom), 1, 0, 0, 2'd1, 12'h000);
      else if (c < 101) step(12'($urandom), 0, 0, 1, 2'd1, 12'h000);
      else if (c < 104) step(12'h000, 0, 0, 0, 2'd1, 12'h000);
      else              step(12'($urandom), c < 294, 0, 0, 2'd1, 12'h000);
      if (got) begin n_tests++; if (obs !== ec) begin n_fail++; $display("FAIL coincide got=%h want=%h", obs, ec); end end
    end
    n_tests++;
    if (o_frame_cnt !== 16'd4) begin n_fail++; $display("FAIL frame_four got=%0d want=4", o_frame_cnt); end
  endtask

  task automatic test_random();
    int rem;
    bit a, hs, vs;
    rem = 0; a = 0;
    do_reset();
    for (int c = 0; c < 6000; c++) begin
      if (rem == 0) begin a = !a; rem = a ? $urandom_range(20, 700) : $urandom_range(1, 12); end
      rem--;
      vs = !a && ($urandom_range(0, 20) == 0);
      hs = !a && ($urandom_range(0, 3) == 0);
      step(12'($urandom), a, hs, vs, 2'($urandom), 12'($urandom));
      if (got) begin n_tests++; if (obs !== ec) begin n_fail++; $display("FAIL random got=%h want=%h", obs, ec); end end
      n_tests++;
      if (o_frame_cnt !== fc) begin n_fail++; $display("FAIL random_frame got=%0d want=%0d", o_frame_cnt, fc); end
    end
  endtask

`ifdef BBOX_OVERLAY_EN
  task automatic test_bbox();
    do_reset();
    bb_x0 = 11'd10; bb_x1 = 11'd20; bb_y0 = 11'd5; bb_y1 = 11'd8; bb_color = 12'hF00; bb_valid = 1'b1;
    for (int c = 0; c < 340; c++) begin
      step(12'($urandom), (c % 34) < 30, 0, 0, 2'd0, 12'h000);
      if (got) begin n_tests++; if (obs !== ec) begin n_fail++; $display("FAIL bbox_unlatched got=%h want=%h", obs, ec); end end
    end
    for (int c = 0; c < 6; c++) begin
      step(12'h000, 0, 0, c == 2, 2'd0, 12'h000);
      if (got) begin n_tests++; if (obs !== ec) begin n_fail++; $display("FAIL bbox_vsync got=%h want=%h", obs, ec); end end
    end
    bb_valid = 1'b0;
    for (int c = 0; c < 408; c++) begin
      step(12'($urandom), (c % 34) < 30, 0, 0, 2'd0, 12'h000);
      if (got) begin n_tests++; if (obs !== ec) begin n_fail++; $display("FAIL bbox_outline got=%h want=%h", obs, ec); end end
    end
  endtask
`endif

  initial begin
    #2 rstn = 1'b0;
    test_reset();
    test_latency();
    test_mode_latch();
    test_gray_solid();
    test_counters();
    test_random();
`ifdef BBOX_OVERLAY_EN
    test_bbox();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
